// File: rtl/csr_file_pkg.sv
// Shared CSR addresses, operation encodings and field positions for the
// machine-mode CSR file.
package csr_file_pkg;

    localparam int MXLEN = 32;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_W    = 2'b01,
        CSR_OP_S    = 2'b10,
        CSR_OP_C    = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam logic [MXLEN-1:0] MSTATUS_MPP_M = 32'h0000_1800;
    localparam logic [MXLEN-1:0] MISA_VALUE    = 32'h4000_1100;

    function automatic logic [MXLEN-1:0] csr_apply(input logic [1:0] op,
                                                   input logic [MXLEN-1:0] old_val,
                                                   input logic [MXLEN-1:0] src);
        case (op)
            CSR_OP_W: csr_apply = src;
            CSR_OP_S: csr_apply = old_val | src;
            CSR_OP_C: csr_apply = old_val & ~src;
            default:  csr_apply = old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit counter built from two 32-bit halves, each independently writable;
// a written half holds the written value and blocks any carry into it.
module csr_counter64
    import csr_file_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             we_lo,
    input  logic             we_hi,
    input  logic [MXLEN-1:0] wdata,
    output logic [63:0]      count
);

    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic        carry;

    assign carry = inc && !we_lo && (lo_q == 32'hFFFF_FFFF);

    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (we_lo)
            lo_d = wdata;
        else if (inc)
            lo_d = lo_q + 32'd1;
        if (we_hi)
            hi_d = wdata;
        else if (carry)
            hi_d = hi_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign count = {hi_q, lo_q};

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational read port for the execute stage,
// edge-committed CSR writes, trap entry, MRET and the 64-bit counters.
module csr_file
    import csr_file_pkg::*;
#(
    parameter logic [MXLEN-1:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic [MXLEN-1:0] HART_ID     = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             csr_en,
    input  logic [1:0]       csr_op,
    input  logic [11:0]      csr_addr,
    input  logic [MXLEN-1:0] csr_src,
    input  logic             csr_src_zero,
    output logic [MXLEN-1:0] csr_rdata,
    output logic             csr_illegal,
    input  logic             trap_req,
    input  logic [MXLEN-1:0] trap_cause,
    input  logic [MXLEN-1:0] trap_pc,
    input  logic             mret,
    input  logic             instret_inc,
    output logic [MXLEN-1:0] trap_vector,
    output logic [MXLEN-1:0] epc,
    output logic             irq_en
);

    logic             mie_q, mpie_q;
    logic [MXLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [63:0]      mcycle, minstret;

    logic [MXLEN-1:0] read_val, new_val;
    logic             implemented, wr_intent, wr_en;

    always_comb begin
        read_val    = '0;
        implemented = 1'b1;
        case (csr_addr)
            CSR_MSTATUS:               read_val = MSTATUS_MPP_M
                                                | (MXLEN'(mpie_q) << MSTATUS_MPIE)
                                                | (MXLEN'(mie_q) << MSTATUS_MIE);
            CSR_MISA:                  read_val = MISA_VALUE;
            CSR_MTVEC:                 read_val = mtvec_q;
            CSR_MSCRATCH:              read_val = mscratch_q;
            CSR_MEPC:                  read_val = mepc_q;
            CSR_MCAUSE:                read_val = mcause_q;
            CSR_MCYCLE,   CSR_CYCLE:   read_val = mcycle[31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:  read_val = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET: read_val = minstret[31:0];
            CSR_MINSTRETH,CSR_INSTRETH:read_val = minstret[63:32];
            CSR_MHARTID:               read_val = HART_ID;
            default:                   implemented = 1'b0;
        endcase
    end

    assign wr_intent   = (csr_op == CSR_OP_W)
                       || (((csr_op == CSR_OP_S) || (csr_op == CSR_OP_C)) && !csr_src_zero);
    assign csr_illegal = csr_en && (!implemented || ((csr_addr[11:10] == 2'b11) && wr_intent));
    assign csr_rdata   = csr_illegal ? '0 : read_val;
    assign new_val     = csr_apply(csr_op, read_val, csr_src);
    // Trap and MRET own the cycle; a coincident CSR write is dropped entirely.
    assign wr_en       = csr_en && wr_intent && !csr_illegal && !trap_req && !mret;

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= RESET_MTVEC & ~32'h3;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else if (trap_req) begin
            mepc_q   <= trap_pc & ~32'h3;
            mcause_q <= trap_cause;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
        end else if (mret) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (wr_en) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie_q  <= new_val[MSTATUS_MIE];
                    mpie_q <= new_val[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec_q    <= new_val & ~32'h3;
                CSR_MSCRATCH: mscratch_q <= new_val;
                CSR_MEPC:     mepc_q     <= new_val & ~32'h3;
                CSR_MCAUSE:   mcause_q   <= new_val;
                default: ;
            endcase
        end
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .we_lo (wr_en && (csr_addr == CSR_MCYCLE)),
        .we_hi (wr_en && (csr_addr == CSR_MCYCLEH)),
        .wdata (new_val),
        .count (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (instret_inc && !trap_req),
        .we_lo (wr_en && (csr_addr == CSR_MINSTRET)),
        .we_hi (wr_en && (csr_addr == CSR_MINSTRETH)),
        .wdata (new_val),
        .count (minstret)
    );

    assign trap_vector = mtvec_q;
    assign epc         = mepc_q;
    assign irq_en      = mie_q;

endmodule
